// File: rtl/ysyx_idu_if.sv
// rtl/ysyx_idu_if.sv - decode-to-execute pipeline bundle with its valid/ready handshake
interface ysyx_idu_if #(
    parameter int REG_LEN = 5
);
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic [31:0]        op1;
    logic [31:0]        op2;
    logic [31:0]        opj;
    logic [31:0]        imm;
    logic [4:0]         alu_op;
    logic [REG_LEN-1:0] rd;
    logic [2:0]         func3;
    logic               ren;
    logic               wen;
    logic               jen;
    logic               ben;
    logic               system;
    logic               func3_z;
    logic               csr_wen;
    logic               ebreak;
    logic               ecall;
    logic               mret;

    modport master (
        output out_valid, pc, inst, op1, op2, opj, imm, alu_op, rd, func3,
               ren, wen, jen, ben, system, func3_z, csr_wen, ebreak, ecall, mret,
        input  out_ready
    );

    modport slave (
        input  out_valid, pc, inst, op1, op2, opj, imm, alu_op, rd, func3,
               ren, wen, jen, ben, system, func3_z, csr_wen, ebreak, ecall, mret,
        output out_ready
    );
endinterface

// File: rtl/ysyx_idu.sv
// rtl/ysyx_idu.sv - RV32I decode stage with register scoreboard; YSYX_IDU_BYPASS_EN adds writeback forwarding
module ysyx_idu #(
    parameter int YSYX_REG_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_inst,
    output logic [YSYX_REG_LEN-1:0] rs1_addr,
    output logic [YSYX_REG_LEN-1:0] rs2_addr,
    input  logic [31:0]             rs1_data,
    input  logic [31:0]             rs2_data,
    input  logic                    wb_valid,
    input  logic [YSYX_REG_LEN-1:0] wb_rd,
    input  logic [31:0]             wb_data,
    input  logic                    flush,
    ysyx_idu_if.master              pipe
);
    localparam int NREG = 1 << YSYX_REG_LEN;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             inst;
        logic [31:0]             op1;
        logic [31:0]             op2;
        logic [31:0]             opj;
        logic [31:0]             imm;
        logic [4:0]              alu_op;
        logic [YSYX_REG_LEN-1:0] rd;
        logic [2:0]              func3;
        logic                    ren;
        logic                    wen;
        logic                    jen;
        logic                    ben;
        logic                    system;
        logic                    func3_z;
        logic                    csr_wen;
        logic                    ebreak;
        logic                    ecall;
        logic                    mret;
    } bundle_t;

    bundle_t         held;
    bundle_t         dec;
    logic            out_valid;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            hazard;
    logic            accept;
    logic            fwd1;
    logic            fwd2;
    logic [31:0]     src1;
    logic [31:0]     src2;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [31:0]     imm_i;
    logic [31:0]     imm_s;
    logic [31:0]     imm_b;
    logic [31:0]     imm_u;
    logic [31:0]     imm_j;

    assign rs1_addr = in_inst[15 +: YSYX_REG_LEN];
    assign rs2_addr = in_inst[20 +: YSYX_REG_LEN];
    assign opcode   = in_inst[6:0];
    assign func3    = in_inst[14:12];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

`ifdef YSYX_IDU_BYPASS_EN
    // A result retiring this cycle satisfies its pending reader directly
    assign fwd1 = wb_valid & busy[rs1_addr] & (wb_rd == rs1_addr);
    assign fwd2 = wb_valid & busy[rs2_addr] & (wb_rd == rs2_addr);
    assign src1 = fwd1 ? wb_data : rs1_data;
    assign src2 = fwd2 ? wb_data : rs2_data;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif

    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        wr_rd       = 1'b0;
        dec.pc      = in_pc;
        dec.inst    = in_inst;
        dec.func3   = func3;
        dec.func3_z = (func3 == 3'b000);
        unique case (opcode)
            OPC_OP: begin
                dec.op1    = src1;
                dec.op2    = src2;
                dec.alu_op = {1'b0, in_inst[30], func3};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                wr_rd      = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.op1    = src1;
                dec.op2    = imm_i;
                dec.imm    = imm_i;
                dec.alu_op = {1'b0, (func3 == 3'b101) & in_inst[30], func3};
                use_rs1    = 1'b1;
                wr_rd      = 1'b1;
            end
            OPC_LOAD: begin
                dec.op1 = src1;
                dec.op2 = imm_i;
                dec.imm = imm_i;
                dec.ren = 1'b1;
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            OPC_STORE: begin
                dec.op1 = src1;
                dec.op2 = imm_s;
                dec.imm = imm_s;
                dec.wen = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LUI: begin
                dec.op2 = imm_u;
                dec.imm = imm_u;
                wr_rd   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op1 = in_pc;
                dec.op2 = imm_u;
                dec.imm = imm_u;
                wr_rd   = 1'b1;
            end
            OPC_JAL: begin
                dec.op1 = in_pc;
                dec.op2 = 32'd4;
                dec.opj = in_pc;
                dec.imm = imm_j;
                dec.jen = 1'b1;
                wr_rd   = 1'b1;
            end
            OPC_JALR: begin
                dec.op1 = in_pc;
                dec.op2 = 32'd4;
                dec.opj = src1;
                dec.imm = imm_i;
                dec.jen = 1'b1;
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op1    = src1;
                dec.op2    = src2;
                dec.opj    = in_pc;
                dec.imm    = imm_b;
                dec.ben    = 1'b1;
                dec.alu_op = {2'b00, func3};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_SYSTEM: begin
                // CSR immediate forms carry a uimm in the rs1 field, not a register
                dec.op1     = src1;
                dec.op2     = imm_i;
                dec.imm     = imm_i;
                dec.alu_op  = {2'b00, func3};
                dec.system  = 1'b1;
                dec.csr_wen = (func3 != 3'b000);
                dec.ecall   = (in_inst == 32'h0000_0073);
                dec.ebreak  = (in_inst == 32'h0010_0073);
                dec.mret    = (in_inst == 32'h3020_0073);
                use_rs1     = (func3 != 3'b000) & ~func3[2];
                wr_rd       = (func3 != 3'b000);
            end
            default: begin
                dec.alu_op = {2'b00, func3};
                dec.ebreak = 1'b1;
            end
        endcase
        dec.rd = wr_rd ? in_inst[7 +: YSYX_REG_LEN] : '0;
    end

    assign hazard   = (use_rs1 & busy[rs1_addr] & ~fwd1) | (use_rs2 & busy[rs2_addr] & ~fwd2);
    assign in_ready = (~out_valid | pipe.out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // Later updates win: a new writer of a register overrides its retiring writeback
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (flush & out_valid) begin
            busy_nxt[held.rd] = 1'b0;
        end
        if (accept) begin
            busy_nxt[dec.rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            held      <= '0;
            busy      <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                held      <= dec;
            end else if (pipe.out_ready) begin
                out_valid <= 1'b0;
            end
            busy <= busy_nxt;
        end
    end

    assign pipe.out_valid = out_valid;
    assign pipe.pc        = held.pc;
    assign pipe.inst      = held.inst;
    assign pipe.op1       = held.op1;
    assign pipe.op2       = held.op2;
    assign pipe.opj       = held.opj;
    assign pipe.imm       = held.imm;
    assign pipe.alu_op    = held.alu_op;
    assign pipe.rd        = held.rd;
    assign pipe.func3     = held.func3;
    assign pipe.ren       = held.ren;
    assign pipe.wen       = held.wen;
    assign pipe.jen       = held.jen;
    assign pipe.ben       = held.ben;
    assign pipe.system    = held.system;
    assign pipe.func3_z   = held.func3_z;
    assign pipe.csr_wen   = held.csr_wen;
    assign pipe.ebreak    = held.ebreak;
    assign pipe.ecall     = held.ecall;
    assign pipe.mret      = held.mret;
endmodule

// File: tb/tb_ysyx_idu.sv
// tb/tb_ysyx_idu.sv - bench for ysyx_idu: behavioural decode/scoreboard model plus directed vectors
module tb_ysyx_idu;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] opj;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic        ren;
        logic        wen;
        logic        jen;
        logic        ben;
        logic        system;
        logic        func3_z;
        logic        csr_wen;
        logic        ebreak;
        logic        ecall;
        logic        mret;
    } bundle_t;

`ifdef YSYX_IDU_BYPASS_EN
    localparam int ADD_LAT = 0;
`else
    localparam int ADD_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [31:0] rf [32];
    int          errors = 0;
    int          checks = 0;

    ysyx_idu_if pipe ();

    ysyx_idu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flush    (flush),
        .pipe     (pipe)
    );

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end

    always @(posedge clk) begin
        if (wb_valid && wb_rd != 0) rf[wb_rd] <= wb_data;
    end

    bundle_t dut_b;
    assign dut_b = {pipe.pc, pipe.inst, pipe.op1, pipe.op2, pipe.opj, pipe.imm, pipe.alu_op,
                    pipe.rd, pipe.func3, pipe.ren, pipe.wen, pipe.jen, pipe.ben, pipe.system,
                    pipe.func3_z, pipe.csr_wen, pipe.ebreak, pipe.ecall, pipe.mret};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: what the stage holds and which registers await a result
    logic    m_valid;
    bundle_t m_b;
    logic [31:0] m_busy;

    function automatic bundle_t model_decode(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic [31:0] a, input logic [31:0] b);
        bundle_t     r;
        logic [2:0]  f3;
        logic [31:0] ii, si, bi, ui, ji;
        f3 = inst[14:12];
        ii = 32'($signed(inst) >>> 20);
        si = (ii & 32'hFFFF_FFE0) | 32'(inst[11:7]);
        bi = (inst[31] ? 32'hFFFF_F000 : 32'h0) + 32'(inst[7]) * 2048 + 32'(inst[30:25]) * 32 + 32'(inst[11:8]) * 2;
        ui = inst & 32'hFFFF_F000;
        ji = (inst[31] ? 32'hFFF0_0000 : 32'h0) + 32'(inst[19:12]) * 4096 + 32'(inst[20]) * 2048 + 32'(inst[30:21]) * 2;
        r = '0;
        r.pc = pc;
        r.inst = inst;
        r.func3 = f3;
        r.func3_z = (f3 == 0);
        case (inst[6:0])
            7'h33: begin r.op1 = a; r.op2 = b; r.alu_op = {1'b0, inst[30], f3}; r.rd = inst[11:7]; end
            7'h13: begin
                r.op1 = a; r.op2 = ii; r.imm = ii; r.rd = inst[11:7];
                r.alu_op = {1'b0, (f3 == 3'b101 && inst[31:25] == 7'b0100000), f3};
            end
            7'h03: begin r.op1 = a; r.op2 = ii; r.imm = ii; r.ren = 1; r.rd = inst[11:7]; end
            7'h23: begin r.op1 = a; r.op2 = si; r.imm = si; r.wen = 1; end
            7'h37: begin r.op2 = ui; r.imm = ui; r.rd = inst[11:7]; end
            7'h17: begin r.op1 = pc; r.op2 = ui; r.imm = ui; r.rd = inst[11:7]; end
            7'h6f: begin r.op1 = pc; r.op2 = 4; r.opj = pc; r.imm = ji; r.jen = 1; r.rd = inst[11:7]; end
            7'h67: begin r.op1 = pc; r.op2 = 4; r.opj = a; r.imm = ii; r.jen = 1; r.rd = inst[11:7]; end
            7'h63: begin r.op1 = a; r.op2 = b; r.opj = pc; r.imm = bi; r.ben = 1; r.alu_op = {2'b0, f3}; end
            7'h73: begin
                r.op1 = a; r.op2 = ii; r.imm = ii; r.system = 1; r.alu_op = {2'b0, f3};
                r.csr_wen = (f3 != 0);
                r.rd = (f3 != 0) ? inst[11:7] : 5'd0;
                r.ecall = (inst == 32'h0000_0073);
                r.ebreak = (inst == 32'h0010_0073);
                r.mret = (inst == 32'h3020_0073);
            end
            default: begin r.ebreak = 1; r.alu_op = {2'b0, f3}; end
        endcase
        return r;
    endfunction

    function automatic logic wb_hits(input logic [4:0] r);
`ifdef YSYX_IDU_BYPASS_EN
        return m_busy[r] && wb_valid && wb_rd == r;
`else
        return (r != r);
`endif
    endfunction

    function automatic logic [31:0] m_src(input logic [4:0] r);
        return wb_hits(r) ? wb_data : rf[r];
    endfunction

    function automatic logic m_hazard();
        logic u1, u2;
        logic [2:0] f3;
        f3 = in_inst[14:12];
        case (in_inst[6:0])
            7'h33, 7'h23, 7'h63: begin u1 = 1; u2 = 1; end
            7'h13, 7'h03, 7'h67: begin u1 = 1; u2 = 0; end
            7'h73: begin u1 = (f3 != 0) && !f3[2]; u2 = 0; end
            default: begin u1 = 0; u2 = 0; end
        endcase
        return (u1 && m_busy[in_inst[19:15]] && !wb_hits(in_inst[19:15])) ||
               (u2 && m_busy[in_inst[24:20]] && !wb_hits(in_inst[24:20]));
    endfunction

    function automatic logic m_ready();
        return (!m_valid || pipe.out_ready) && !m_hazard() && !flush;
    endfunction

    function automatic bundle_t m_dec();
        return model_decode(in_pc, in_inst, m_src(in_inst[19:15]), m_src(in_inst[24:20]));
    endfunction

    function automatic logic [31:0] m_busy_next();
        logic [31:0] nb;
        nb = m_busy;
        if (wb_valid) nb[wb_rd] = 1'b0;
        if (flush && m_valid) nb[m_b.rd] = 1'b0;
        if (in_valid && m_ready() && m_dec().rd != 0) nb[m_dec().rd] = 1'b1;
        return nb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_b     <= '0;
            m_busy  <= '0;
        end else begin
            if (flush) m_valid <= 1'b0;
            else if (in_valid && m_ready()) begin
                m_valid <= 1'b1;
                m_b     <= m_dec();
            end else if (pipe.out_ready) m_valid <= 1'b0;
            m_busy <= m_busy_next();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_in_ready", in_ready, m_ready());
            check("m_out_valid", pipe.out_valid, m_valid);
            check("m_rs_addr", {rs1_addr, rs2_addr}, {in_inst[19:15], in_inst[24:20]});
            if (m_valid) check("m_bundle", dut_b, m_b);
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        logic got;
        got = 1'b0;
        in_pc = pc;
        in_inst = inst;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) check("issue_timeout", 1'b0, 1'b1);
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd = rd;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    logic [31:0] prog [16];
    int          n;
    logic        got;

    initial begin
        pipe.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", pipe.out_valid, 1'b0);
        check("rst_bundle", dut_b, '0);
        rst_n = 1'b1;
        pipe.out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        issue(32'h8000_0000, 32'h0050_0093);
        check("addi_valid", pipe.out_valid, 1'b1);
        check("addi_pc", pipe.pc, 32'h8000_0000);
        check("addi_op1", pipe.op1, 32'd0);
        check("addi_op2", pipe.op2, 32'd5);
        check("addi_rd", pipe.rd, 5'd1);
        check("addi_alu_op", pipe.alu_op, 5'd0);

        in_pc = 32'h8000_0004;
        in_inst = 32'h0010_8133;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("add_stall", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        wb_valid = 1'b1;
        wb_rd = 5'd1;
        wb_data = 32'd5;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            wb_valid = 1'b0;
            if (!got) n++;
        end
        in_valid = 1'b0;
        check("add_latency", n, ADD_LAT);
        check("add_op1", pipe.op1, 32'd5);
        check("add_op2", pipe.op2, 32'd5);
        check("add_rd", pipe.rd, 5'd2);

        issue(32'h8000_0008, 32'h0070_0213);
        pipe.out_ready = 1'b0;
        in_inst = 32'h0010_0293;
        in_pc = 32'h8000_000C;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_valid", pipe.out_valid, 1'b1);
            check("hold_op2", pipe.op2, 32'd7);
            check("hold_rd", pipe.rd, 5'd4);
            @(posedge clk);
            #1;
        end
        pipe.out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_release_rd", pipe.rd, 5'd5);

        issue(32'h8000_0010, 32'h0000_2183);
        pipe.out_ready = 1'b0;
        check("lw_rd", pipe.rd, 5'd3);
        flush = 1'b1;
        pipe.out_ready = 1'b1;
        in_inst = 32'h0010_0313;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", pipe.out_valid, 1'b0);
        in_inst = 32'h0001_83B3;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_x3_free", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("flush_next_inst", pipe.inst, 32'h0001_83B3);

        writeback(5'd2, 32'd10);
        issue(32'h0000_0100, 32'hFE20_8CE3);
        check("beq_ben", pipe.ben, 1'b1);
        check("beq_opj", pipe.opj, 32'h100);
        check("beq_imm", pipe.imm, 32'hFFFF_FFF8);
        check("beq_rd", pipe.rd, 5'd0);
        check("beq_ops", {pipe.op1, pipe.op2}, {32'd5, 32'd10});

        issue(32'h0000_0200, 32'h1234_5437);
        check("lui_op2", pipe.op2, 32'h1234_5000);
        issue(32'h0000_0204, 32'hFFFF_F497);
        check("auipc_ops", {pipe.op1, pipe.op2}, {32'h204, 32'hFFFF_F000});
        issue(32'h0000_0300, enc_j(21'(-16), 5'd10));
        check("jal_fields", {pipe.imm, pipe.opj, pipe.op2}, {32'hFFFF_FFF0, 32'h300, 32'd4});

        prog[0]  = enc_i(12'd12, 5'd1, 3'b000, 5'd11, 7'h67);
        prog[1]  = enc_s(12'(-4), 5'd2, 5'd1, 3'b010);
        prog[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd12, 7'h33);
        prog[3]  = enc_i(12'h403, 5'd1, 3'b101, 5'd13, 7'h13);
        prog[4]  = enc_i(12'h003, 5'd1, 3'b101, 5'd14, 7'h13);
        prog[5]  = enc_i(12'hFFF, 5'd2, 3'b010, 5'd15, 7'h13);
        prog[6]  = enc_i(12'h300, 5'd1, 3'b001, 5'd16, 7'h73);
        prog[7]  = enc_i(12'h341, 5'd5, 3'b110, 5'd17, 7'h73);
        prog[8]  = 32'h0000_0073;
        prog[9]  = 32'h0010_0073;
        prog[10] = 32'h3020_0073;
        prog[11] = 32'h0000_000F;
        prog[12] = enc_b(13'd2046, 5'd2, 5'd1, 3'b001);
        prog[13] = enc_i(12'd2047, 5'd2, 3'b010, 5'd18, 7'h03);
        prog[14] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd19, 7'h33);
        prog[15] = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) issue(32'h0000_0400 + 32'(i) * 4, prog[i]);

        wb_valid = 1'b1;
        wb_rd = 5'd20;
        wb_data = 32'd77;
        issue(32'h0000_0500, enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'h13));
        wb_valid = 1'b0;
        in_inst = enc_r(7'h00, 5'd0, 5'd20, 3'b000, 5'd21, 7'h33);
        in_valid = 1'b1;
        @(negedge clk);
        check("set_wins", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        writeback(5'd20, 32'd1);

        issue(32'h0000_0600, 32'h0090_0B13);
        pipe.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", pipe.out_valid, 1'b0);
        check("rst_mid_bundle", dut_b, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pipe.out_ready = 1'b1;
        in_inst = enc_r(7'h00, 5'd0, 5'd22, 3'b000, 5'd23, 7'h33);
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_busy_clear", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_next_rd", pipe.rd, 5'd23);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ysyx_idu.md
YSYX_IDU -- requirements
Module: ysyx_idu

Interface
REQ-001 The block SHALL expose these ports: clock, input, 1, sole clock, rising edge.
REQ-002 The block SHALL expose these ports: reset, input, 1, asynchronous, active-low.
REQ-003 The block SHALL expose these ports: in_valid/in_ready, input/output, 1/1, fetch handshake.
REQ-004 The block SHALL expose these ports: in_pc/in_inst, input, 32/32, fetched PC and instruction.
REQ-005 The block SHALL expose these ports: rs1_addr/rs2_addr, output, YSYX_REG_LEN each, register-file read addresses taken from in_inst[19:15]/[24:20].
REQ-006 The block SHALL expose these ports: rs1_data/rs2_data, input, 32 each, combinational register-file read data.
REQ-007 The block SHALL expose these ports: wb_valid input 1; wb_rd input YSYX_REG_LEN; wb_data input 32 — writeback report.
REQ-008 The block SHALL expose these ports: flush, input, 1, downstream redirect.
REQ-009 The block SHALL expose these ports: out_valid/out_ready, output/input, 1/1, execute handshake.
REQ-010 The block SHALL expose these ports: idu_pipe_if.out, output, bundle — pc, inst, op1, op2, opj, alu_op, rd, imm, ren, wen, jen, ben, func3, system, func3_z, csr_wen, ebreak, ecall, mret.

Function
REQ-011 The block SHALL hold a single-entry output register: accept = in_valid & in_ready; bundle and out_valid update on the edge after accept (latency 1).
REQ-012 The block SHALL drive in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-013 The block SHALL hold bundle fields stable while out_valid & ~out_ready.
REQ-014 The block SHALL set out_valid on accept and clear it on out_ready without a new accept.
REQ-015 The block SHALL keep a scoreboard of one busy bit per register, with x0 never busy.
REQ-016 Scoreboard set: on accept of an instruction with rd≠0 writing rd (OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, CSR).
REQ-017 Scoreboard clear: on wb_valid for wb_rd; a same-cycle set and clear of one register SHALL resolve to set.
REQ-018 Hazard SHALL be declared when a used source (rs1 and/or rs2 per opcode) is busy.
REQ-019 Operand mapping: OP op1=rs1, op2=rs2; OP-IMM/LOAD op1=rs1, op2=imm; STORE op1=rs1, op2=imm, rd=0.
REQ-020 Operand mapping: LUI op1=0, op2=imm; AUIPC op1=pc, op2=imm; JAL op1=pc, op2=4, opj=pc; JALR op1=pc, op2=4, opj=rs1; BRANCH op1=rs1, op2=rs2, opj=pc.
REQ-021 Immediates SHALL be sign-extended per I/S/B/U/J format.
REQ-022 alu_op SHALL be {1'b0, inst[30] for OP and for SRAI, else 0, func3}, forced to add (0) for LUI/AUIPC/JAL/JALR/LOAD/STORE.
REQ-023 ren=LOAD, wen=STORE, jen=JAL|JALR, ben=BRANCH, system=SYSTEM opcode, func3_z=(func3==0), csr_wen=system&~func3_z.
REQ-024 ecall/ebreak/mret SHALL decode from the full instruction word; an unknown opcode SHALL set ebreak=1 with rd=0.
REQ-025 flush SHALL clear out_valid and the busy bit of the held entry's rd, and the same-cycle in_valid SHALL be dropped.

Reset
REQ-026 Reset SHALL clear out_valid, all busy bits and all bundle fields to 0 asynchronously; in_ready SHALL be 1 on the first edge after release.
REQ-027 Reset asserted mid-handshake SHALL discard the held entry with no partial state retained.

Configuration
REQ-028 With YSYX_IDU_BYPASS_EN defined, a busy source matching wb_rd under wb_valid SHALL not cause a hazard, and wb_data SHALL replace rs*_data for that operand.
REQ-029 With YSYX_IDU_BYPASS_EN undefined, the block SHALL stall until the cycle after the busy bit clears.

Verification
REQ-030 ADDI x1,x0,5 at pc 0x80000000 with out_ready=1: out_valid next cycle, op1=0, op2=5, rd=1, alu_op=0.
REQ-031 ADDI x1 followed by ADD x2,x1,x1: in_ready=0 until wb_valid with wb_rd=1, wb_data=5; with bypass, op1=op2=5 in the same cycle; without bypass, one cycle later.
REQ-032 out_ready=0 for 3 cycles with an entry held: bundle stable and in_ready=0 throughout.
REQ-033 flush while holding LW x3: out_valid=0 next cycle, x3 not busy, and the concurrent in_valid is not accepted.
REQ-034 BEQ x1,x2,-8 at pc 0x100: ben=1, opj=0x100, imm=0xFFFFFFF8, rd=0.
REQ-035 Reset asserted while out_valid=1: out_valid=0 immediately and all busy bits cleared.
